// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared frame-buffer geometry, clear FSM encoding and address helper
package vram_pkg;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_WORDS = FB_W * FB_H;
    localparam int AW       = 18;
    localparam int CW       = 17;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

    // y*320 is built from two shifts so no multiplier is inferred
    function automatic logic [AW-1:0] fb_addr(input logic buf_sel,
                                              input logic [7:0] y,
                                              input logic [8:0] x);
        logic [AW-1:0] yw;
        logic [AW-1:0] base;
        yw   = AW'(y);
        base = buf_sel ? AW'(FB_WORDS) : '0;
        return base + (yw << 8) + (yw << 6) + AW'(x);
    endfunction

endpackage

// File: rtl/vram_scheduler_if.sv
// rtl/vram_scheduler_if.sv - host pixel-write handshake and frame-buffer RAM bus
interface vram_scheduler_if;
    import vram_pkg::*;

    logic          wr_req;
    logic [8:0]    wr_x;
    logic [7:0]    wr_y;
    logic [11:0]   wr_data;
    logic          wr_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [11:0]   ram_wdata;
    logic [11:0]   ram_rdata;

    modport slave (
        input  wr_req, wr_x, wr_y, wr_data, ram_rdata,
        output wr_ack, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output wr_req, wr_x, wr_y, wr_data, ram_rdata,
        input  wr_ack, ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/vram_clear_engine.sv
// rtl/vram_clear_engine.sv - back-buffer fill FSM: one word per granted write slot
module vram_clear_engine
    import vram_pkg::*;
(
    input  logic          clk_25MHz,
    input  logic          rst,
    input  logic          clr_start,
    input  logic [11:0]   clr_color,
    input  logic          slot_grant,
    output logic          clr_busy,
    output logic [AW-1:0] clr_offset,
    output logic [11:0]   clr_wdata,
    output logic          clr_we
);

    localparam logic [CW-1:0] LAST = CW'(FB_WORDS - 1);

    clr_state_t    state;
    logic [CW-1:0] count;

    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            state     <= CLR_IDLE;
            count     <= '0;
            clr_busy  <= 1'b0;
            clr_wdata <= '0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_start) begin
                        clr_wdata <= clr_color;
                        count     <= '0;
                        clr_busy  <= 1'b1;
                        state     <= CLR_CLEAR;
                    end
                end
                CLR_CLEAR: begin
                    if (slot_grant) begin
                        if (count == LAST) begin
                            count    <= '0;
                            clr_busy <= 1'b0;
                            state    <= CLR_IDLE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= CLR_IDLE;
            endcase
        end
    end

    assign clr_offset = AW'(count);
    assign clr_we     = clr_busy & slot_grant;

endmodule

// File: rtl/vram_scheduler.sv
// rtl/vram_scheduler.sv - time-shares the frame-buffer RAM between display, host writer and clear engine
module vram_scheduler
    import vram_pkg::*;
(
    input  logic             clk_25MHz,
    input  logic             rst,
    input  logic [8:0]       row,
    input  logic [9:0]       col,
    input  logic             rdn,
    input  logic             vs,
    output logic [11:0]      vga_din,
    input  logic             clr_start,
    input  logic [11:0]      clr_color,
    output logic             clr_busy,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic             front_buf,
    vram_scheduler_if.slave  bus
);

    logic          disp_slot;
    logic          write_slot;
    logic          host_grant;
    logic          host_in_range;
    logic          clr_we;
    logic [AW-1:0] clr_offset;
    logic [11:0]   clr_wdata;
    logic [AW-1:0] back_base;
    logic [AW-1:0] disp_addr;
    logic [AW-1:0] host_addr;
    logic          disp_q;
    logic          vs_q;
    logic          vs_fall;
    logic          unused_row_lsb;

    // row/col are pixel-doubled, so the low bits only choose the slot type
    assign disp_slot      = ~rdn & ~col[0];
    assign write_slot     = ~disp_slot;
    assign unused_row_lsb = row[0];

    assign back_base     = fb_addr(~front_buf, 8'd0, 9'd0);
    assign disp_addr     = fb_addr(front_buf, row[8:1], col[9:1]);
    assign host_addr     = fb_addr(~front_buf, bus.wr_y, bus.wr_x);
    assign host_in_range = (bus.wr_x < 9'(FB_W)) && (bus.wr_y < 8'(FB_H));
    assign host_grant    = write_slot & ~clr_busy & bus.wr_req;

    vram_clear_engine u_clear (
        .clk_25MHz  (clk_25MHz),
        .rst        (rst),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .slot_grant (write_slot),
        .clr_busy   (clr_busy),
        .clr_offset (clr_offset),
        .clr_wdata  (clr_wdata),
        .clr_we     (clr_we)
    );

    // single priority mux so the RAM bus never mixes two clients in one cycle
    always_comb begin
        bus.wr_ack    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        if (rst) begin
            if (disp_slot) begin
                bus.ram_addr = disp_addr;
            end else if (clr_we) begin
                bus.ram_addr  = back_base + clr_offset;
                bus.ram_we    = 1'b1;
                bus.ram_wdata = clr_wdata;
            end else if (host_grant) begin
                bus.wr_ack    = 1'b1;
                bus.ram_addr  = host_addr;
                bus.ram_we    = host_in_range;
                bus.ram_wdata = bus.wr_data;
            end
        end
    end

    assign vs_fall = vs_q & ~vs;

    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            disp_q       <= 1'b0;
            vga_din      <= '0;
            vs_q         <= 1'b0;
            swap_pending <= 1'b0;
            front_buf    <= 1'b0;
        end else begin
            disp_q <= disp_slot;
            if (disp_q) begin
                vga_din <= bus.ram_rdata;
            end
            vs_q <= vs;
            // a swap during a clear would expose a half-filled buffer, so hold it
            if (vs_fall && (swap_pending || swap_req) && !clr_busy) begin
                front_buf    <= ~front_buf;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_scheduler.sv
// tb/tb_vram_scheduler.sv - directed self-checking bench for vram_scheduler
module tb_vram_scheduler;
    import vram_pkg::*;

    logic        clk_25MHz = 1'b0;
    logic        rst;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        rdn;
    logic        vs;
    logic [11:0] vga_din;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        swap_req;
    logic        swap_pending;
    logic        front_buf;

    logic        pl_we;
    logic [17:0] pl_addr;
    logic [11:0] pl_data;
    logic [11:0] mem [0:153599];

    int total = 0;
    int bad   = 0;

    vram_scheduler_if bus();

    vram_scheduler dut (
        .clk_25MHz    (clk_25MHz),
        .rst          (rst),
        .row          (row),
        .col          (col),
        .rdn          (rdn),
        .vs           (vs),
        .vga_din      (vga_din),
        .clr_start    (clr_start),
        .clr_color    (clr_color),
        .clr_busy     (clr_busy),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .front_buf    (front_buf),
        .bus          (bus)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    always @(posedge clk_25MHz) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_25MHz);
    endtask

    initial begin
        int nw;
        int nack;
        int nfront;
        int nbad_data;
        int nfill_bad;
        logic [11:0] exp_disp [0:3];
        logic done;

        exp_disp[0] = 12'hABC; exp_disp[1] = 12'hABC;
        exp_disp[2] = 12'h123; exp_disp[3] = 12'h123;

        rst = 1'b0; row = '0; col = '0; rdn = 1'b1; vs = 1'b1;
        clr_start = 1'b0; clr_color = '0; swap_req = 1'b0;
        bus.wr_req = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;

        // reset state
        step(); step(); #1;
        chk("rst_vga_din", 32'(vga_din), 0);
        chk("rst_wr_ack", 32'(bus.wr_ack), 0);
        chk("rst_clr_busy", 32'(clr_busy), 0);
        chk("rst_swap_pending", 32'(swap_pending), 0);
        chk("rst_front_buf", 32'(front_buf), 0);
        chk("rst_ram_we", 32'(bus.ram_we), 0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 0);
        step(); rst = 1'b1;
        step();

        // swap via pending flag
        swap_req = 1'b1;
        step(); swap_req = 1'b0; #1;
        chk("swap_pending_set", 32'(swap_pending), 1);
        chk("swap_front_held", 32'(front_buf), 0);
        step(); vs = 1'b0;
        step(); vs = 1'b1; #1;
        chk("swap_front_toggled", 32'(front_buf), 1);
        chk("swap_pending_clr", 32'(swap_pending), 0);

        // swap_req coincident with vs falling edge, twice
        for (int k = 0; k < 2; k++) begin
            step(); swap_req = 1'b1; vs = 1'b0;
            step(); swap_req = 1'b0; vs = 1'b1; #1;
            chk("swap_coinc_front", 32'(front_buf), (k == 0) ? 32'd0 : 32'd1);
            chk("swap_coinc_pending", 32'(swap_pending), 0);
        end

        // reset in the middle of a clear (back buffer is 0 while front_buf=1)
        step(); clr_start = 1'b1; clr_color = 12'h0F0;
        step(); clr_start = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) step();
            #1;
            if (k == 0) begin
                chk("clr_busy_rise", 32'(clr_busy), 1);
                chk("clr_first_addr", 32'(bus.ram_addr), 0);
                chk("clr_first_we", 32'(bus.ram_we), 1);
            end
            if (k == 999) chk("clr_addr_999", 32'(bus.ram_addr), 999);
        end
        step(); rst = 1'b0; #1;
        chk("midclr_busy", 32'(clr_busy), 0);
        chk("midclr_front", 32'(front_buf), 0);
        chk("midclr_we", 32'(bus.ram_we), 0);
        step(); step(); rst = 1'b1;
        nw = 0;
        for (int k = 0; k < 20; k++) begin
            step(); #1;
            if (bus.ram_we) nw++;
        end
        chk("postrst_no_writes", 32'(nw), 0);

        // display fetch from front buffer 0
        step(); pl_we = 1'b1; pl_addr = 18'd0; pl_data = 12'hABC;
        step(); pl_addr = 18'd1; pl_data = 12'h123;
        step(); pl_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            row = 9'd0; col = 10'(i); rdn = (i < 4) ? 1'b0 : 1'b1;
            #1;
            if (i == 0 || i == 2) chk("disp_we_even", 32'(bus.ram_we), 0);
            if (i == 2) chk("disp_addr_col2", 32'(bus.ram_addr), 1);
            if (i >= 2) chk("disp_vga_din", 32'(vga_din), 32'(exp_disp[i-2]));
        end

        // host write: held off in display slot, granted in write slot
        step(); rdn = 1'b0; col = 10'd0;
        bus.wr_req = 1'b1; bus.wr_x = 9'd5; bus.wr_y = 8'd2; bus.wr_data = 12'hF00; #1;
        chk("host_no_ack_disp", 32'(bus.wr_ack), 0);
        chk("host_no_we_disp", 32'(bus.ram_we), 0);
        step(); col = 10'd1; #1;
        chk("host_ack", 32'(bus.wr_ack), 1);
        chk("host_addr", 32'(bus.ram_addr), 77445);
        chk("host_we", 32'(bus.ram_we), 1);
        chk("host_wdata", 32'(bus.ram_wdata), 12'hF00);
        step(); rdn = 1'b1; bus.wr_x = 9'd320; #1;
        chk("host_mem", 32'(mem[77445]), 12'hF00);
        chk("host_oor_ack", 32'(bus.wr_ack), 1);
        chk("host_oor_we", 32'(bus.ram_we), 0);
        step(); bus.wr_x = 9'd0; bus.wr_y = 8'd240; #1;
        chk("host_oor_y_we", 32'(bus.ram_we), 0);
        step(); bus.wr_req = 1'b0;

        // full clear with host held off and a deferred swap
        swap_req = 1'b1;
        step(); swap_req = 1'b0;
        clr_start = 1'b1; clr_color = 12'h00F;
        step(); clr_start = 1'b0;
        bus.wr_req = 1'b1; bus.wr_x = 9'd1; bus.wr_y = 8'd1; bus.wr_data = 12'hFFF;
        nw = 0; nack = 0; nfront = 0; nbad_data = 0; done = 1'b0;
        for (int i = 0; i < 80000; i++) begin
            if (i > 0) step();
            vs = (i == 100) ? 1'b0 : 1'b1;
            #1;
            if (i == 103) begin
                chk("defer_front", 32'(front_buf), 0);
                chk("defer_pending", 32'(swap_pending), 1);
            end
            if (!clr_busy) begin
                done = 1'b1;
                break;
            end
            if (bus.wr_ack) nack++;
            if (bus.ram_we) begin
                nw++;
                if (bus.ram_addr < 18'(FB_WORDS)) nfront++;
                if (bus.ram_wdata != 12'h00F) nbad_data++;
            end
        end
        chk("clr_done", 32'(done), 1);
        chk("clr_write_count", 32'(nw), FB_WORDS);
        chk("clr_no_host_ack", 32'(nack), 0);
        chk("clr_front_untouched", 32'(nfront), 0);
        chk("clr_wdata", 32'(nbad_data), 0);
        chk("host_ack_after_clr", 32'(bus.wr_ack), 1);
        nfill_bad = 0;
        for (int k = 0; k < FB_WORDS; k++)
            if (mem[FB_WORDS + k] !== 12'h00F) nfill_bad++;
        chk("clr_fill", 32'(nfill_bad), 0);
        chk("clr_front_word0", 32'(mem[0]), 12'hABC);

        step(); bus.wr_req = 1'b0; vs = 1'b0;
        step(); vs = 1'b1; #1;
        chk("deferred_front", 32'(front_buf), 1);
        chk("deferred_pending", 32'(swap_pending), 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
